smac_out_stage: RTL and testbench

Output stage of the SMAC engine. It captures each final convolution accumulator value on `valid_ac3`, requantizes it to activation width through a 2-stage pipeline, and stores one result per filter. Once the buffer is full it raises `done_quant`. While the control FSM holds `wb`/`act_wb` (in its WRITE_BACK state), it drains the results to activation memory through a valid/ready handshake, applying ReLU on the way out, and pulses `relu_done` when the last result is accepted.

---
 rtl/smac_out_stage.sv | 100 ++++++++++
 tb/tb_smac_out_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/smac_out_stage.sv
// smac_out_stage: requantize accumulators, buffer one result per filter, drain with optional ReLU (SMAC_OUT_ROUND_EN enables round-half-up)
module smac_out_stage #(
  parameter int ACC_W   = 32,
  parameter int ACT_W   = 8,
  parameter int N_FIL   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_ac3,
  input  logic [ACC_W-1:0]         acc_in,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     wb,
  input  logic                     act_wb,
  input  logic                     mem_ready,
  output logic                     mem_valid,
  output logic [ACT_W-1:0]         mem_data,
  output logic [$clog2(N_FIL)-1:0] mem_addr,
  output logic                     done_quant,
  output logic                     relu_done,
  output logic                     ovf_err
);
  localparam int AW = $clog2(N_FIL);
  localparam logic [AW:0] NF = (AW+1)'(N_FIL);
  localparam logic [AW-1:0] LAST = AW'(N_FIL - 1);
  localparam logic [SHIFT_W-1:0] SMAX = SHIFT_W'(ACC_W - 1);
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'((1 << (ACT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] LO = -HI - 1;
  typedef enum logic [1:0] {FILL, FULL, DRAIN, DONE} state_t;
  state_t state;
  logic [AW:0] wr_ptr, cnt;
  logic [AW-1:0] rd_ptr;
  logic p1, p2, accept;
  logic [SHIFT_W-1:0] s_eff;
  logic signed [ACC_W:0] ext, rnd, sum, r_next, r1;
  logic signed [ACT_W-1:0] q_next, q2, cur;
  logic signed [ACT_W-1:0] mem_buf [N_FIL];
  // Q1 arithmetic is done one bit wider so the rounding add cannot wrap
  always_comb begin
    accept = (state == FILL) && valid_ac3 && (cnt < NF);
    s_eff = (int'(shift) > ACC_W - 1) ? SMAX : shift;
    ext = {acc_in[ACC_W-1], acc_in};
`ifdef SMAC_OUT_ROUND_EN
    rnd = (s_eff == '0) ? '0 : ((ACC_W+1)'(1) <<< (s_eff - 1'b1));
`else
    rnd = '0;
`endif
    sum = ext + rnd;
    r_next = sum >>> s_eff;
    q_next = (r1 > HI) ? HI[ACT_W-1:0] : (r1 < LO) ? LO[ACT_W-1:0] : r1[ACT_W-1:0];
    cur = mem_buf[rd_ptr];
    mem_valid = (state == DRAIN);
    done_quant = (state == FULL);
    relu_done = (state == DONE);
    mem_addr = mem_valid ? rd_ptr : '0;
    mem_data = !mem_valid ? '0 : (act_wb && cur[ACT_W-1]) ? '0 : cur;
  end
  // Capture pipeline, pointers, sticky overflow and the fill/drain FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      wr_ptr <= '0;
      cnt <= '0;
      rd_ptr <= '0;
      p1 <= 1'b0;
      p2 <= 1'b0;
      r1 <= '0;
      q2 <= '0;
      ovf_err <= 1'b0;
    end else begin
      p1 <= accept;
      p2 <= p1;
      if (accept) begin
        r1 <= r_next;
        cnt <= cnt + 1'b1;
      end
      if (p1) q2 <= q_next;
      if (p2) wr_ptr <= wr_ptr + 1'b1;
      if (valid_ac3 && !accept) ovf_err <= 1'b1;
      case (state)
        FILL:  if (p2 && wr_ptr == NF - 1'b1) state <= FULL;
        FULL:  if (wb) state <= DRAIN;
        DRAIN: if (mem_ready) begin
          rd_ptr <= rd_ptr + 1'b1;
          if (rd_ptr == LAST) state <= DONE;
        end
        default: begin
          state <= FILL;
          wr_ptr <= '0;
          cnt <= '0;
          rd_ptr <= '0;
        end
      endcase
    end
  end
  // Result buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (p2) mem_buf[wr_ptr[AW-1:0]] <= q2;
  end
endmodule

// File: tb/tb_smac_out_stage.sv
// tb_smac_out_stage: random and directed captures checked against an arithmetic requantize/ReLU model
module tb_smac_out_stage;
  localparam int NF = 4;
  logic clk = 0, rst_n = 0, valid_ac3 = 0, wb = 0, act_wb = 0, mem_ready = 0;
  logic signed [31:0] acc_in = 0;
  logic [4:0] shift = 0;
  logic mem_valid, done_quant, relu_done, ovf_err;
  logic signed [7:0] mem_data;
  logic [1:0] mem_addr;
  int total = 0, bad = 0;
  int exp_q[$];

  smac_out_stage #(.ACC_W(32), .ACT_W(8), .N_FIL(NF), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ac3(valid_ac3), .acc_in(acc_in), .shift(shift),
    .wb(wb), .act_wb(act_wb), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_data(mem_data), .mem_addr(mem_addr), .done_quant(done_quant),
    .relu_done(relu_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_q(int a, int sh);
    longint v = longint'(a);
    int s = (sh > 31) ? 31 : sh;
`ifdef SMAC_OUT_ROUND_EN
    if (s > 0) v = v + (longint'(1) << (s - 1));
`endif
    v = v >>> s;
    return (v > 127) ? 127 : (v < -128) ? -128 : int'(v);
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(int a, int s);
    valid_ac3 = 1;
    acc_in = a;
    shift = s[4:0];
    exp_q.push_back(ref_q(a, s));
    tick;
    valid_ac3 = 0;
  endtask

  task automatic wait_full;
    int n = 0;
    while (!done_quant && n < 20) begin
      tick;
      n++;
    end
    chk("done_quant_rise", done_quant, 1);
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1,..., 2: random ready
  task automatic drain(bit act, int mode, bit inject, int stop_at);
    int k = 0, idx = 0;
    wait_full;
    chk("full_no_valid", mem_valid, 0);
    wb = 1;
    act_wb = act;
    tick;
    wb = 0;
    while (idx < stop_at && k < 100) begin
      mem_ready = (mode == 0) || (mode == 1 ? (k % 4 == 0 || k % 4 == 3) : $urandom_range(0, 1) == 1);
      valid_ac3 = inject && k == 0;
      #1;
      chk("mem_valid", mem_valid, 1);
      chk("mem_addr", mem_addr, idx);
      chk("mem_data", mem_data, (act && exp_q[idx] < 0) ? 0 : exp_q[idx]);
      chk("relu_early", relu_done, 0);
      chk("dq_in_drain", done_quant, 0);
      if (mem_ready) idx++;
      k++;
      tick;
    end
    valid_ac3 = 0;
    mem_ready = 0;
    chk("drain_words", idx, stop_at);
    if (stop_at == NF) begin
      chk("relu_done", relu_done, 1);
      chk("mem_valid_off", mem_valid, 0);
      tick;
      chk("relu_pulse", relu_done, 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int a[4] = '{1000, 1100, -22, -40000};
    int s[4] = '{3, 3, 2, 4};
    int ra, rs;
    repeat (2) tick;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done_quant", done_quant, 0);
    chk("rst_relu_done", relu_done, 0);
    chk("rst_ovf_err", ovf_err, 0);
    rst_n = 1;
    tick;
    for (int i = 0; i < NF; i++) capture(a[i], s[i]);
    drain(0, 0, 0, NF);
    chk("ovf_clean", ovf_err, 0);
    for (int i = 0; i < NF; i++) capture(a[i], s[i]);
    drain(1, 0, 0, NF);
    repeat (3) begin
      for (int i = 0; i < NF; i++) capture(int'($urandom), int'($urandom_range(0, 31)));
      drain($urandom_range(0, 1) == 1, 1, 0, NF);
    end
    for (int i = 0; i < 5; i++) begin
      ra = int'($urandom);
      rs = int'($urandom_range(0, 31));
      valid_ac3 = 1;
      acc_in = ra;
      shift = rs[4:0];
      if (i < NF) exp_q.push_back(ref_q(ra, rs));
      if (i == 4) chk("dq_c1", done_quant, 0);
      tick;
    end
    valid_ac3 = 0;
    chk("dq_c2", done_quant, 0);
    chk("ovf_set", ovf_err, 1);
    tick;
    chk("dq_c3", done_quant, 1);
    drain(0, 1, 1, NF);
    chk("ovf_sticky", ovf_err, 1);
    for (int i = 0; i < NF; i++) capture(int'($urandom), int'($urandom_range(0, 31)));
    drain(0, 0, 0, 2);
    rst_n = 0;
    #1;
    chk("mid_rst_mem_valid", mem_valid, 0);
    chk("mid_rst_mem_data", mem_data, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_done_quant", done_quant, 0);
    chk("mid_rst_relu_done", relu_done, 0);
    chk("mid_rst_ovf_err", ovf_err, 0);
    tick;
    rst_n = 1;
    exp_q.delete();
    tick;
    for (int i = 0; i < NF; i++) capture(int'($urandom), int'($urandom_range(0, 31)));
    drain(1, 2, 0, NF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
